lc3_mem_access: RTL and testbench

Memory-side counterpart of the LC-3 datapath's effective-address adder: holds the MAR/MDR pair and runs each read or write to the synchronous on-board memory, using a fixed wait-state count. The address adder produces an address onto the datapath bus. This block latches that address into MAR, performs the access, and returns a one-cycle ready pulse (R) that the ISDU control FSM waits on in its memory states. It sits between the datapath bus and the memory/SRAM wrapper.

---
 rtl/lc3_mem_pkg.sv | 14 +
 rtl/lc3_mem_wait_timer.sv | 27 ++
 rtl/lc3_mem_access.sv | 116 +++++++++++
 tb/tb_lc3_mem_access.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/lc3_mem_pkg.sv
// rtl/lc3_mem_pkg.sv - shared types and constants for the LC-3 memory access block
package lc3_mem_pkg;

  localparam int WORD_W = 16;
  localparam int WAIT_W = 4;
  localparam logic [WORD_W-1:0] MMIO_ADDR = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } mem_state_t;

endpackage

// File: rtl/lc3_mem_wait_timer.sv
// rtl/lc3_mem_wait_timer.sv - loadable wait-state down-counter with zero flag
module lc3_mem_wait_timer
  import lc3_mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [WAIT_W-1:0] load_val,
  input  logic              dec,
  output logic              zero
);

  logic [WAIT_W-1:0] count;

  assign zero = (count == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && !zero) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/lc3_mem_access.sv
// rtl/lc3_mem_access.sv - MAR/MDR and fixed wait-state memory access FSM; LC3_MEM_MMIO_EN maps 16'hFFFF to SW/HEX_OUT
module lc3_mem_access
  import lc3_mem_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [WORD_W-1:0] BUS,
  input  logic              LD_MAR,
  input  logic              LD_MDR,
  input  logic              MEM_START,
  input  logic              MEM_WE,
  input  logic [WORD_W-1:0] MEM_DIN,
  input  logic [WORD_W-1:0] SW,
  output logic [WORD_W-1:0] MAR,
  output logic [WORD_W-1:0] MDR,
  output logic              R,
  output logic              BUSY,
  output logic [WORD_W-1:0] MEM_ADDR,
  output logic [WORD_W-1:0] MEM_DOUT,
  output logic              MEM_CE,
  output logic              MEM_WR,
  output logic [WORD_W-1:0] HEX_OUT
);

  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_CYCLES - 1);

  mem_state_t        state, state_next;
  logic              op_we;
  logic              timer_load, timer_dec, timer_zero;
  logic              access_done;
  logic              mmio_hit;
  logic [WORD_W-1:0] rd_data;

  lc3_mem_wait_timer u_timer (
    .clk      (Clk),
    .reset    (Reset),
    .load     (timer_load),
    .load_val (WAIT_INIT),
    .dec      (timer_dec),
    .zero     (timer_zero)
  );

`ifdef LC3_MEM_MMIO_EN
  assign mmio_hit = (MAR == MMIO_ADDR);
  assign rd_data  = mmio_hit ? SW : MEM_DIN;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      HEX_OUT <= '0;
    end else if (access_done && op_we && mmio_hit) begin
      HEX_OUT <= MDR;
    end
  end
`else
  logic unused_sw;
  assign unused_sw = ^SW;
  assign mmio_hit  = 1'b0;
  assign rd_data   = MEM_DIN;
  assign HEX_OUT   = '0;
`endif

  always_comb begin
    state_next  = state;
    timer_load  = 1'b0;
    timer_dec   = 1'b0;
    access_done = 1'b0;
    case (state)
      IDLE: begin
        if (MEM_START) begin
          state_next = ACCESS;
          timer_load = 1'b1;
        end
      end
      ACCESS: begin
        if (timer_zero) begin
          state_next  = DONE;
          access_done = 1'b1;
        end else begin
          timer_dec = 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Loads are gated to IDLE so the address and write data hold for the whole access.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      op_we <= 1'b0;
      MAR   <= '0;
      MDR   <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE) begin
        if (LD_MAR)    MAR   <= BUS;
        if (LD_MDR)    MDR   <= BUS;
        if (MEM_START) op_we <= MEM_WE;
      end
      if (access_done && !op_we) begin
        MDR <= rd_data;
      end
    end
  end

  assign BUSY     = (state != IDLE);
  assign R        = (state == DONE);
  assign MEM_CE   = (state == ACCESS) && !mmio_hit;
  assign MEM_WR   = MEM_CE && op_we;
  assign MEM_ADDR = MAR;
  assign MEM_DOUT = MDR;

endmodule

// File: tb/tb_lc3_mem_access.sv
// tb/tb_lc3_mem_access.sv - directed vector bench for lc3_mem_access (optionally with LC3_MEM_MMIO_EN)
module tb_lc3_mem_access;

`ifdef LC3_MEM_MMIO_EN
  localparam bit MM = 1'b1;
`else
  localparam bit MM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] bus, din;
  logic        ld_mar, ld_mdr, start, we;
  logic [15:0] sw = 16'h00A5;

  logic [15:0] mar, mdr, maddr, mdout, hex;
  logic        r, busy, ce, wr;
  logic [15:0] mar1, mdr1, maddr1, mdout1, hex1;
  logic        r1, busy1, ce1, wr1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lc3_mem_access #(.WAIT_CYCLES(2)) dut (
    .Clk(clk), .Reset(rst), .BUS(bus), .LD_MAR(ld_mar), .LD_MDR(ld_mdr),
    .MEM_START(start), .MEM_WE(we), .MEM_DIN(din), .SW(sw),
    .MAR(mar), .MDR(mdr), .R(r), .BUSY(busy), .MEM_ADDR(maddr),
    .MEM_DOUT(mdout), .MEM_CE(ce), .MEM_WR(wr), .HEX_OUT(hex)
  );

  lc3_mem_access #(.WAIT_CYCLES(1)) dut1 (
    .Clk(clk), .Reset(rst), .BUS(bus), .LD_MAR(ld_mar), .LD_MDR(ld_mdr),
    .MEM_START(start), .MEM_WE(we), .MEM_DIN(din), .SW(sw),
    .MAR(mar1), .MDR(mdr1), .R(r1), .BUSY(busy1), .MEM_ADDR(maddr1),
    .MEM_DOUT(mdout1), .MEM_CE(ce1), .MEM_WR(wr1), .HEX_OUT(hex1)
  );

  typedef struct {
    logic        lm, lmd, st, we;
    logic [15:0] bus, din;
    logic [15:0] emar, emdr;
    logic        er, eb, ece, ewr;
    logic [15:0] ehex;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t v(input logic lm, lmd, st, w, input logic [15:0] b, d,
                             input logic [15:0] emar, emdr, input logic er, eb, ece, ewr,
                             input logic [15:0] ehex);
    vec_t x;
    x.lm = lm; x.lmd = lmd; x.st = st; x.we = w; x.bus = b; x.din = d;
    x.emar = emar; x.emdr = emdr; x.er = er; x.eb = eb; x.ece = ece; x.ewr = ewr;
    x.ehex = ehex;
    return x;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic idle_in();
    ld_mar = 0; ld_mdr = 0; start = 0; we = 0; bus = 16'h0; din = 16'h0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] rdv, hxv;
  logic        nce;

  initial begin
    rdv = MM ? 16'h00A5 : 16'h0F0F;
    hxv = MM ? 16'h5A5A : 16'h0000;
    nce = !MM;

    vt.push_back(v(1,0,1,0,16'h3000,16'h0000, 16'h0000,16'h0000, 0,0,0,0,16'h0));
    vt.push_back(v(0,0,0,0,16'h0000,16'hBEEF, 16'h3000,16'h0000, 0,1,1,0,16'h0));
    vt.push_back(v(0,0,0,0,16'h0000,16'hBEEF, 16'h3000,16'h0000, 0,1,1,0,16'h0));
    vt.push_back(v(0,0,0,0,16'h0000,16'h0000, 16'h3000,16'hBEEF, 1,1,0,0,16'h0));
    vt.push_back(v(0,1,0,0,16'h1234,16'h0000, 16'h3000,16'hBEEF, 0,0,0,0,16'h0));
    vt.push_back(v(1,0,1,1,16'h3001,16'h0000, 16'h3000,16'h1234, 0,0,0,0,16'h0));
    vt.push_back(v(0,0,0,0,16'h0000,16'h0000, 16'h3001,16'h1234, 0,1,1,1,16'h0));
    vt.push_back(v(0,0,0,0,16'h0000,16'hFFFF, 16'h3001,16'h1234, 0,1,1,1,16'h0));
    vt.push_back(v(0,0,0,0,16'h0000,16'hFFFF, 16'h3001,16'h1234, 1,1,0,0,16'h0));
    vt.push_back(v(0,0,0,0,16'h0000,16'h0000, 16'h3001,16'h1234, 0,0,0,0,16'h0));
    // requests and loads arriving mid-access must be dropped
    vt.push_back(v(1,0,1,0,16'h3002,16'h0000, 16'h3001,16'h1234, 0,0,0,0,16'h0));
    vt.push_back(v(1,1,1,0,16'h0005,16'hCAFE, 16'h3002,16'h1234, 0,1,1,0,16'h0));
    vt.push_back(v(1,1,1,0,16'h0005,16'hCAFE, 16'h3002,16'h1234, 0,1,1,0,16'h0));
    vt.push_back(v(1,1,1,0,16'h0005,16'h0000, 16'h3002,16'hCAFE, 1,1,0,0,16'h0));
    vt.push_back(v(0,0,0,0,16'h0000,16'h0000, 16'h3002,16'hCAFE, 0,0,0,0,16'h0));
    vt.push_back(v(1,0,1,0,16'hFFFF,16'h0000, 16'h3002,16'hCAFE, 0,0,0,0,16'h0));
    vt.push_back(v(0,0,0,0,16'h0000,16'h0F0F, 16'hFFFF,16'hCAFE, 0,1,nce,0,16'h0));
    vt.push_back(v(0,0,0,0,16'h0000,16'h0F0F, 16'hFFFF,16'hCAFE, 0,1,nce,0,16'h0));
    vt.push_back(v(0,0,0,0,16'h0000,16'h0000, 16'hFFFF,rdv,      1,1,0,0,16'h0));
    vt.push_back(v(0,1,0,0,16'h5A5A,16'h0000, 16'hFFFF,rdv,      0,0,0,0,16'h0));
    vt.push_back(v(0,0,1,1,16'h0000,16'h0000, 16'hFFFF,16'h5A5A, 0,0,0,0,16'h0));
    vt.push_back(v(0,0,0,0,16'h0000,16'h0000, 16'hFFFF,16'h5A5A, 0,1,nce,nce,16'h0));
    vt.push_back(v(0,0,0,0,16'h0000,16'h0000, 16'hFFFF,16'h5A5A, 0,1,nce,nce,16'h0));
    vt.push_back(v(0,0,0,0,16'h0000,16'h0000, 16'hFFFF,16'h5A5A, 1,1,0,0,hxv));
    vt.push_back(v(1,1,1,1,16'h4444,16'h0000, 16'hFFFF,16'h5A5A, 0,0,0,0,hxv));
    vt.push_back(v(0,0,0,0,16'h0000,16'h0000, 16'h4444,16'h4444, 0,1,1,1,hxv));
    vt.push_back(v(0,0,0,0,16'h0000,16'h0000, 16'h4444,16'h4444, 0,1,1,1,hxv));
    vt.push_back(v(0,0,0,0,16'h0000,16'h0000, 16'h4444,16'h4444, 1,1,0,0,hxv));
    vt.push_back(v(0,0,0,0,16'h0000,16'h0000, 16'h4444,16'h4444, 0,0,0,0,hxv));

    rst = 1'b1;
    idle_in();
    cyc();
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mar", -1, mar, 16'h0);
    chk("rst_mdr", -1, mdr, 16'h0);
    chk("rst_r", -1, {15'h0, r}, 16'h0);
    chk("rst_busy", -1, {15'h0, busy}, 16'h0);
    chk("rst_ce", -1, {15'h0, ce}, 16'h0);
    chk("rst_wr", -1, {15'h0, wr}, 16'h0);
    chk("rst_hex", -1, hex, 16'h0);

    foreach (vt[i]) begin
      cyc();
      ld_mar = vt[i].lm; ld_mdr = vt[i].lmd; start = vt[i].st; we = vt[i].we;
      bus = vt[i].bus; din = vt[i].din;
      @(negedge clk);
      chk("mar", i, mar, vt[i].emar);
      chk("mem_addr", i, maddr, vt[i].emar);
      chk("mdr", i, mdr, vt[i].emdr);
      chk("mem_dout", i, mdout, vt[i].emdr);
      chk("r", i, {15'h0, r}, {15'h0, vt[i].er});
      chk("busy", i, {15'h0, busy}, {15'h0, vt[i].eb});
      chk("mem_ce", i, {15'h0, ce}, {15'h0, vt[i].ece});
      chk("mem_wr", i, {15'h0, wr}, {15'h0, vt[i].ewr});
      chk("hex_out", i, hex, vt[i].ehex);
    end

    // reset asserted in the first ACCESS cycle of a read
    cyc();
    idle_in(); ld_mar = 1; start = 1; bus = 16'h2000;
    cyc();
    idle_in(); rst = 1; din = 16'hDEAD;
    @(negedge clk);
    chk("abort_ce_before", 1, {15'h0, ce}, 16'h1);
    cyc();
    rst = 0;
    @(negedge clk);
    chk("abort_ce", 2, {15'h0, ce}, 16'h0);
    chk("abort_wr", 2, {15'h0, wr}, 16'h0);
    chk("abort_busy", 2, {15'h0, busy}, 16'h0);
    for (int k = 0; k < 4; k++) begin
      chk("abort_r", 3 + k, {15'h0, r}, 16'h0);
      chk("abort_mdr", 3 + k, mdr, 16'h0);
      cyc();
      @(negedge clk);
    end

    // single wait state on the WAIT_CYCLES=1 instance
    cyc();
    idle_in(); ld_mar = 1; start = 1; bus = 16'h0100;
    cyc();
    idle_in(); din = 16'h1357;
    @(negedge clk);
    chk("w1_ce_c1", 1, {15'h0, ce1}, 16'h1);
    chk("w1_mar_c1", 1, mar1, 16'h0100);
    cyc();
    idle_in();
    @(negedge clk);
    chk("w1_ce_c2", 2, {15'h0, ce1}, 16'h0);
    chk("w1_r_c2", 2, {15'h0, r1}, 16'h1);
    chk("w1_mdr_c2", 2, mdr1, 16'h1357);
    chk("w2_ce_c2", 2, {15'h0, ce}, 16'h1);
    cyc();
    @(negedge clk);
    chk("w1_r_c3", 3, {15'h0, r1}, 16'h0);
    chk("w1_busy_c3", 3, {15'h0, busy1}, 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
